// File: rtl/writeback_pkg.sv
// writeback_pkg: op-class encodings and exception codes shared by the
// writeback controller, its resolver and its interface.
package writeback_pkg;

  typedef enum logic [2:0] {
    OP_ADD_R = 3'd0,
    OP_SUB_R = 3'd1,
    OP_ADDI  = 3'd2,
    OP_JAL   = 3'd3,
    OP_SETX  = 3'd4,
    OP_MULT  = 3'd5,
    OP_DIV   = 3'd6,
    OP_OTHER = 3'd7
  } op_e;

  // rstatus codes; zero means "no exception"
  localparam logic [2:0] EXC_NONE  = 3'd0;
  localparam logic [2:0] EXC_ADD_R = 3'd1;
  localparam logic [2:0] EXC_ADDI  = 3'd2;
  localparam logic [2:0] EXC_SUB_R = 3'd3;
  localparam logic [2:0] EXC_MULT  = 3'd4;
  localparam logic [2:0] EXC_DIV   = 3'd5;

endpackage

// File: rtl/writeback_if.sv
// writeback_if: bundles the ALU/control result handshake, the multdiv
// completion port and the registered regfile write / status outputs.
//   master : drives in_*, overflow, pc_in, t, md_*; observes the rest
//   slave  : the writeback controller side
interface writeback_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int PC_W   = 12,
  parameter int T_W    = 27,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic              in_we;
  logic [REG_W-1:0]  in_reg;
  logic [DATA_W-1:0] in_data;
  logic              overflow;
  logic [PC_W-1:0]   pc_in;
  logic [T_W-1:0]    t;

  logic              md_ready;
  logic              md_exception;
  logic              md_op;
  logic [REG_W-1:0]  md_reg;
  logic [DATA_W-1:0] md_result;

  logic              wb_we;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] status;
  logic [CNT_W-1:0]  exc_count;

  modport master (
    output in_valid, in_op, in_we, in_reg, in_data, overflow, pc_in, t,
    output md_ready, md_exception, md_op, md_reg, md_result,
    input  in_ready, wb_we, wb_reg, wb_data, status, exc_count
  );

  modport slave (
    input  in_valid, in_op, in_we, in_reg, in_data, overflow, pc_in, t,
    input  md_ready, md_exception, md_op, md_reg, md_result,
    output in_ready, wb_we, wb_reg, wb_data, status, exc_count
  );
endinterface

// File: rtl/wb_resolve.sv
// wb_resolve: combinational write resolution for one write source.
// Ports:
//   op, we, rd, data        - raw write request from the source
//   overflow, exception     - ALU overflow / multdiv exception flags
//   pc, t                   - JAL PC and SETX immediate
//   res_we, res_reg, res_data - resolved regfile write
//   res_exc, res_setx       - write is an exception code / a SETX value
import writeback_pkg::*;

module wb_resolve #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int PC_W       = 12,
  parameter int T_W        = 27,
  parameter int STATUS_REG = 30,
  parameter int LINK_REG   = 31
) (
  input  op_e               op,
  input  logic              we,
  input  logic [REG_W-1:0]  rd,
  input  logic [DATA_W-1:0] data,
  input  logic              overflow,
  input  logic              exception,
  input  logic [PC_W-1:0]   pc,
  input  logic [T_W-1:0]    t,
  output logic              res_we,
  output logic [REG_W-1:0]  res_reg,
  output logic [DATA_W-1:0] res_data,
  output logic              res_exc,
  output logic              res_setx
);

  logic [2:0] code;

  always_comb begin
    code = EXC_NONE;
    if (overflow) begin
      case (op)
        OP_ADD_R: code = EXC_ADD_R;
        OP_ADDI:  code = EXC_ADDI;
        OP_SUB_R: code = EXC_SUB_R;
        default:  code = EXC_NONE;
      endcase
    end
    if (exception) begin
      case (op)
        OP_MULT: code = EXC_MULT;
        OP_DIV:  code = EXC_DIV;
        default: ;
      endcase
    end
  end

  always_comb begin
    res_we   = we;
    res_reg  = rd;
    res_data = data;
    res_exc  = 1'b0;
    res_setx = 1'b0;
    if (code != EXC_NONE) begin
      res_we   = 1'b1;
      res_reg  = REG_W'(STATUS_REG);
      res_data = DATA_W'(code);
      res_exc  = 1'b1;
    end else if (op == OP_SETX) begin
      res_we   = 1'b1;
      res_reg  = REG_W'(STATUS_REG);
      res_data = DATA_W'($signed(t));
      res_setx = 1'b1;
    end else if (op == OP_JAL) begin
      // one extra bit so pc wrap-around carries into the link value
      res_we   = 1'b1;
      res_reg  = REG_W'(LINK_REG);
      res_data = DATA_W'({1'b0, pc} + (PC_W+1)'(1));
    end
    if (res_reg == '0) res_we = 1'b0;
  end

endmodule

// File: rtl/writeback_ctrl.sv
// writeback_ctrl: arbitrates multdiv results, a one-entry skid buffer and
// new ALU/control results onto a single registered regfile write port,
// and tracks the sticky exception status and a saturating exception count.
// Ports:
//   clock, reset - single clock, synchronous active-high reset
//   bus          - writeback_if.slave (input handshake, multdiv, wb/status)
import writeback_pkg::*;

module writeback_ctrl #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int PC_W       = 12,
  parameter int T_W        = 27,
  parameter int CNT_W      = 8,
  parameter int STATUS_REG = 30,
  parameter int LINK_REG   = 31
) (
  input  logic       clock,
  input  logic       reset,
  writeback_if.slave bus
);

  logic              skid_valid;
  op_e               skid_op;
  logic              skid_we;
  logic [REG_W-1:0]  skid_reg;
  logic [DATA_W-1:0] skid_data;
  logic              skid_ovf;
  logic [PC_W-1:0]   skid_pc;
  logic [T_W-1:0]    skid_t;

  logic              wb_we_q;
  logic [REG_W-1:0]  wb_reg_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] status_q;
  logic [CNT_W-1:0]  exc_count_q;

  logic              in_ready;
  logic              accept;
  logic              skid_load;

  logic              in_we_r,   skid_we_r,   md_we_r;
  logic [REG_W-1:0]  in_reg_r,  skid_reg_r,  md_reg_r;
  logic [DATA_W-1:0] in_data_r, skid_data_r, md_data_r;
  logic              in_exc,    skid_exc,    md_exc;
  logic              in_setx,   skid_setx,   md_setx;

  logic              sel_valid;
  logic              sel_we;
  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              sel_exc;
  logic              sel_setx;

  assign in_ready = ~skid_valid;
  assign accept   = bus.in_valid & in_ready;
  // an accepted input loses to multdiv and parks in the skid
  assign skid_load = accept & bus.md_ready;

  wb_resolve #(
    .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W), .T_W(T_W),
    .STATUS_REG(STATUS_REG), .LINK_REG(LINK_REG)
  ) u_res_in (
    .op(op_e'(bus.in_op)), .we(bus.in_we), .rd(bus.in_reg), .data(bus.in_data),
    .overflow(bus.overflow), .exception(1'b0), .pc(bus.pc_in), .t(bus.t),
    .res_we(in_we_r), .res_reg(in_reg_r), .res_data(in_data_r),
    .res_exc(in_exc), .res_setx(in_setx)
  );

  wb_resolve #(
    .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W), .T_W(T_W),
    .STATUS_REG(STATUS_REG), .LINK_REG(LINK_REG)
  ) u_res_skid (
    .op(skid_op), .we(skid_we), .rd(skid_reg), .data(skid_data),
    .overflow(skid_ovf), .exception(1'b0), .pc(skid_pc), .t(skid_t),
    .res_we(skid_we_r), .res_reg(skid_reg_r), .res_data(skid_data_r),
    .res_exc(skid_exc), .res_setx(skid_setx)
  );

  wb_resolve #(
    .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W), .T_W(T_W),
    .STATUS_REG(STATUS_REG), .LINK_REG(LINK_REG)
  ) u_res_md (
    .op(bus.md_op ? OP_DIV : OP_MULT), .we(1'b1), .rd(bus.md_reg),
    .data(bus.md_result), .overflow(1'b0), .exception(bus.md_exception),
    .pc('0), .t('0),
    .res_we(md_we_r), .res_reg(md_reg_r), .res_data(md_data_r),
    .res_exc(md_exc), .res_setx(md_setx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_we    = 1'b0;
    sel_reg   = '0;
    sel_data  = '0;
    sel_exc   = 1'b0;
    sel_setx  = 1'b0;
    if (bus.md_ready) begin
      sel_valid = 1'b1;
      sel_we    = md_we_r;
      sel_reg   = md_reg_r;
      sel_data  = md_data_r;
      sel_exc   = md_exc;
      sel_setx  = md_setx;
    end else if (skid_valid) begin
      sel_valid = 1'b1;
      sel_we    = skid_we_r;
      sel_reg   = skid_reg_r;
      sel_data  = skid_data_r;
      sel_exc   = skid_exc;
      sel_setx  = skid_setx;
    end else if (accept) begin
      sel_valid = 1'b1;
      sel_we    = in_we_r;
      sel_reg   = in_reg_r;
      sel_data  = in_data_r;
      sel_exc   = in_exc;
      sel_setx  = in_setx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      skid_valid <= 1'b0;
      skid_op    <= OP_ADD_R;
      skid_we    <= 1'b0;
      skid_reg   <= '0;
      skid_data  <= '0;
      skid_ovf   <= 1'b0;
      skid_pc    <= '0;
      skid_t     <= '0;
    end else if (skid_load) begin
      skid_valid <= 1'b1;
      skid_op    <= op_e'(bus.in_op);
      skid_we    <= bus.in_we;
      skid_reg   <= bus.in_reg;
      skid_data  <= bus.in_data;
      skid_ovf   <= bus.overflow;
      skid_pc    <= bus.pc_in;
      skid_t     <= bus.t;
    end else if (skid_valid && !bus.md_ready) begin
      skid_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_we_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      status_q    <= '0;
      exc_count_q <= '0;
    end else begin
      wb_we_q <= sel_valid & sel_we;
      if (sel_valid) begin
        wb_reg_q  <= sel_reg;
        wb_data_q <= sel_data;
      end
      if (sel_valid && (sel_exc || sel_setx)) status_q <= sel_data;
      if (sel_valid && sel_exc && (exc_count_q != '1))
        exc_count_q <= exc_count_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_reg    = wb_reg_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.status    = status_q;
  assign bus.exc_count = exc_count_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
module tb_writeback_ctrl;

  localparam int OP_ADD_R = 0, OP_SUB_R = 1, OP_ADDI = 2, OP_JAL = 3;
  localparam int OP_SETX = 4, OP_MULT = 5, OP_DIV = 6, OP_OTHER = 7;

  typedef struct {
    int          op;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        ovf;
    logic        exc;
    logic [11:0] pc;
    logic [26:0] t;
  } txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  writeback_if bus ();

  writeback_ctrl dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  int tests_run = 0;
  int fails = 0;

  // reference state
  txn_t        pend[$];
  logic        exp_we;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;
  logic [31:0] exp_status;
  int          exp_count;
  logic        last_acc;

  // kind: 0 plain write, 1 exception code, 2 setx
  function automatic void ref_resolve(input txn_t x, output logic o_we,
                                      output logic [4:0] o_reg,
                                      output logic [31:0] o_data,
                                      output int kind);
    int code;
    longint v;
    code = 0;
    if (x.ovf) code = (x.op == OP_ADD_R) ? 1 : (x.op == OP_ADDI) ? 2 :
                      (x.op == OP_SUB_R) ? 3 : 0;
    if (x.exc && code == 0) code = (x.op == OP_MULT) ? 4 : (x.op == OP_DIV) ? 5 : 0;
    o_we = x.we; o_reg = x.rd; o_data = x.d; kind = 0;
    if (code != 0) begin
      o_we = 1; o_reg = 30; o_data = code; kind = 1;
    end else if (x.op == OP_SETX) begin
      v = x.t;
      if (v >= 64'sd67108864) v = v - 64'sd134217728;
      o_we = 1; o_reg = 30; o_data = 32'(v); kind = 2;
    end else if (x.op == OP_JAL) begin
      o_we = 1; o_reg = 31; o_data = 32'(x.pc) + 32'd1;
    end
    if (o_reg == 0) o_we = 0;
  endfunction

  function automatic txn_t cur_in();
    txn_t x;
    x.op = int'(bus.in_op); x.we = bus.in_we; x.rd = bus.in_reg; x.d = bus.in_data;
    x.ovf = bus.overflow; x.exc = 1'b0; x.pc = bus.pc_in; x.t = bus.t;
    return x;
  endfunction

  // advance model by the current cycle's inputs, then clock the DUT
  task automatic tick();
    txn_t x;
    logic have, w;
    logic [4:0] r;
    logic [31:0] d;
    int kind;
    logic acc;
    have = 0;
    if (reset) begin
      pend.delete();
      exp_we = 0; exp_reg = 0; exp_data = 0; exp_status = 0; exp_count = 0;
      last_acc = 0;
    end else begin
      acc = bus.in_valid && (pend.size() == 0);
      last_acc = acc;
      if (bus.md_ready) begin
        x.op = bus.md_op ? OP_DIV : OP_MULT; x.we = 1; x.rd = bus.md_reg;
        x.d = bus.md_result; x.ovf = 0; x.exc = bus.md_exception; x.pc = 0; x.t = 0;
        have = 1;
        if (acc) pend.push_back(cur_in());
      end else if (pend.size() > 0) begin
        x = pend.pop_front();
        have = 1;
      end else if (acc) begin
        x = cur_in();
        have = 1;
      end
      exp_we = 0;
      if (have) begin
        ref_resolve(x, w, r, d, kind);
        exp_we = w; exp_reg = r; exp_data = d;
        if (kind == 1) begin
          exp_status = d;
          if (exp_count < 255) exp_count++;
        end else if (kind == 2) exp_status = d;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid = 0; bus.in_op = 3'(OP_OTHER); bus.in_we = 0; bus.in_reg = 0;
    bus.in_data = 0; bus.overflow = 0; bus.pc_in = 0; bus.t = 0;
    bus.md_ready = 0; bus.md_exception = 0; bus.md_op = 0; bus.md_reg = 0;
    bus.md_result = 0;
  endtask

  task automatic set_in(input int op, input logic we, input logic [4:0] rd,
                        input logic [31:0] d, input logic ovf,
                        input logic [11:0] pc, input logic [26:0] tt);
    bus.in_valid = 1; bus.in_op = 3'(op); bus.in_we = we; bus.in_reg = rd;
    bus.in_data = d; bus.overflow = ovf; bus.pc_in = pc; bus.t = tt;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1;
    tick(); tick();
    tests_run++; if (bus.wb_we !== 1'b0) begin fails++; $display("FAIL reset_wb_we: got %0h expected 0", bus.wb_we); end
    tests_run++; if (bus.wb_reg !== 5'd0) begin fails++; $display("FAIL reset_wb_reg: got %0h expected 0", bus.wb_reg); end
    tests_run++; if (bus.wb_data !== 32'd0) begin fails++; $display("FAIL reset_wb_data: got %0h expected 0", bus.wb_data); end
    tests_run++; if (bus.status !== 32'd0) begin fails++; $display("FAIL reset_status: got %0h expected 0", bus.status); end
    tests_run++; if (bus.exc_count !== 8'd0) begin fails++; $display("FAIL reset_exc_count: got %0h expected 0", bus.exc_count); end
    reset = 0;
    tick();
    tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0h expected 1", bus.in_ready); end
  endtask

  task automatic test_add_overflow();
    set_in(OP_ADD_R, 1, 5'd7, 32'h1234, 1, 0, 0);
    tick();
    clear_in();
    tests_run++; if (bus.wb_we !== 1'b1) begin fails++; $display("FAIL add_ovf_we: got %0h expected 1", bus.wb_we); end
    tests_run++; if (bus.wb_reg !== 5'd30) begin fails++; $display("FAIL add_ovf_reg: got %0d expected 30", bus.wb_reg); end
    tests_run++; if (bus.wb_data !== 32'd1) begin fails++; $display("FAIL add_ovf_data: got %0h expected 1", bus.wb_data); end
    tests_run++; if (bus.status !== 32'd1) begin fails++; $display("FAIL add_ovf_status: got %0h expected 1", bus.status); end
    tests_run++; if (bus.exc_count !== 8'd1) begin fails++; $display("FAIL add_ovf_count: got %0d expected 1", bus.exc_count); end
  endtask

  task automatic test_jal();
    set_in(OP_JAL, 0, 5'd3, 32'hDEAD, 0, 12'hFFF, 0);
    tick();
    clear_in();
    tests_run++; if (bus.wb_we !== 1'b1) begin fails++; $display("FAIL jal_we: got %0h expected 1", bus.wb_we); end
    tests_run++; if (bus.wb_reg !== 5'd31) begin fails++; $display("FAIL jal_reg: got %0d expected 31", bus.wb_reg); end
    tests_run++; if (bus.wb_data !== 32'h1000) begin fails++; $display("FAIL jal_data: got %0h expected 1000", bus.wb_data); end
  endtask

  task automatic test_setx();
    set_in(OP_SETX, 0, 5'd9, 32'h0, 0, 0, 27'h4000000);
    tick();
    clear_in();
    tests_run++; if (bus.wb_we !== 1'b1) begin fails++; $display("FAIL setx_we: got %0h expected 1", bus.wb_we); end
    tests_run++; if (bus.wb_reg !== 5'd30) begin fails++; $display("FAIL setx_reg: got %0d expected 30", bus.wb_reg); end
    tests_run++; if (bus.wb_data !== 32'hFC000000) begin fails++; $display("FAIL setx_data: got %0h expected fc000000", bus.wb_data); end
    tests_run++; if (bus.status !== 32'hFC000000) begin fails++; $display("FAIL setx_status: got %0h expected fc000000", bus.status); end
    tests_run++; if (bus.exc_count !== 8'd1) begin fails++; $display("FAIL setx_count: got %0d expected 1", bus.exc_count); end
  endtask

  task automatic test_r0();
    set_in(OP_OTHER, 1, 5'd0, 32'h55, 0, 0, 0);
    tick();
    clear_in();
    tests_run++; if (bus.wb_we !== 1'b0) begin fails++; $display("FAIL r0_we: got %0h expected 0", bus.wb_we); end
    tick();
    tests_run++; if (bus.wb_we !== 1'b0) begin fails++; $display("FAIL idle_we: got %0h expected 0", bus.wb_we); end
    tests_run++; if (bus.wb_data !== 32'h55) begin fails++; $display("FAIL idle_hold_data: got %0h expected 55", bus.wb_data); end
  endtask

  task automatic test_md_collision();
    set_in(OP_ADDI, 1, 5'd5, 32'd9, 0, 0, 0);
    bus.md_ready = 1; bus.md_op = 1; bus.md_exception = 1; bus.md_reg = 5'd12;
    bus.md_result = 32'h77;
    tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL coll_ready0: got %0h expected 1", bus.in_ready); end
    tick();
    clear_in();
    tests_run++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL coll_ready1: got %0h expected 0", bus.in_ready); end
    tests_run++; if (bus.wb_reg !== 5'd30) begin fails++; $display("FAIL coll_md_reg: got %0d expected 30", bus.wb_reg); end
    tests_run++; if (bus.wb_data !== 32'd5) begin fails++; $display("FAIL coll_md_data: got %0h expected 5", bus.wb_data); end
    tests_run++; if (bus.exc_count !== 8'd2) begin fails++; $display("FAIL coll_count: got %0d expected 2", bus.exc_count); end
    tick();
    tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL coll_ready2: got %0h expected 1", bus.in_ready); end
    tests_run++; if (bus.wb_we !== 1'b1) begin fails++; $display("FAIL coll_skid_we: got %0h expected 1", bus.wb_we); end
    tests_run++; if (bus.wb_reg !== 5'd5) begin fails++; $display("FAIL coll_skid_reg: got %0d expected 5", bus.wb_reg); end
    tests_run++; if (bus.wb_data !== 32'd9) begin fails++; $display("FAIL coll_skid_data: got %0h expected 9", bus.wb_data); end
  endtask

  task automatic test_reset_skid();
    set_in(OP_OTHER, 1, 5'd6, 32'hABC, 0, 0, 0);
    bus.md_ready = 1; bus.md_reg = 5'd4; bus.md_result = 32'h11;
    tick();
    clear_in();
    tests_run++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rskid_full: got %0h expected 0", bus.in_ready); end
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rskid_ready c%0d: got %0h expected 1", i, bus.in_ready); end
      tests_run++; if (bus.wb_we !== 1'b0) begin fails++; $display("FAIL rskid_we c%0d: got %0h expected 0", i, bus.wb_we); end
      tick();
    end
  endtask

  task automatic test_saturation();
    set_in(OP_ADD_R, 1, 5'd2, 32'd0, 1, 0, 0);
    for (int i = 0; i < 255; i++) tick();
    tests_run++; if (bus.exc_count !== 8'd255) begin fails++; $display("FAIL sat_255: got %0d expected 255", bus.exc_count); end
    set_in(OP_SUB_R, 1, 5'd2, 32'd0, 1, 0, 0);
    tick();
    clear_in();
    tests_run++; if (bus.exc_count !== 8'd255) begin fails++; $display("FAIL sat_256: got %0d expected 255", bus.exc_count); end
    tests_run++; if (bus.status !== 32'd3) begin fails++; $display("FAIL sat_status: got %0h expected 3", bus.status); end
  endtask

  task automatic test_random();
    reset = 1;
    clear_in();
    tick();
    reset = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!bus.in_valid || last_acc) begin
        bus.in_valid = ($urandom_range(0, 9) < 6);
        bus.in_op    = 3'($urandom_range(0, 7));
        bus.in_we    = 1'($urandom);
        bus.in_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        bus.in_data  = $urandom;
        bus.overflow = ($urandom_range(0, 3) == 0);
        bus.pc_in    = 12'($urandom);
        bus.t        = 27'($urandom);
      end
      bus.md_ready     = ($urandom_range(0, 9) < 3);
      bus.md_exception = ($urandom_range(0, 4) == 0);
      bus.md_op        = 1'($urandom);
      bus.md_reg       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.md_result    = $urandom;
      reset = ($urandom_range(0, 99) == 0);
      tests_run++;
      if (bus.in_ready !== (pend.size() == 0)) begin
        fails++; $display("FAIL rnd_in_ready i=%0d: got %0h expected %0h", i, bus.in_ready, pend.size() == 0);
      end
      tick();
      tests_run++; if (bus.wb_we !== exp_we) begin fails++; $display("FAIL rnd_wb_we i=%0d: got %0h expected %0h", i, bus.wb_we, exp_we); end
      tests_run++; if (bus.wb_reg !== exp_reg) begin fails++; $display("FAIL rnd_wb_reg i=%0d: got %0d expected %0d", i, bus.wb_reg, exp_reg); end
      tests_run++; if (bus.wb_data !== exp_data) begin fails++; $display("FAIL rnd_wb_data i=%0d: got %0h expected %0h", i, bus.wb_data, exp_data); end
      tests_run++; if (bus.status !== exp_status) begin fails++; $display("FAIL rnd_status i=%0d: got %0h expected %0h", i, bus.status, exp_status); end
      tests_run++; if (int'(bus.exc_count) != exp_count) begin fails++; $display("FAIL rnd_exc_count i=%0d: got %0d expected %0d", i, bus.exc_count, exp_count); end
    end
    reset = 0;
    clear_in();
  endtask

  initial begin
    last_acc = 0;
    clear_in();
    test_reset();
    test_add_overflow();
    test_jal();
    test_setx();
    test_r0();
    test_md_collision();
    test_reset_skid();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
